// File: rtl/fxp_divider.sv
// Signed fixed-point divider. Uses sequential restoring division on the operand
// magnitudes and produces one quotient bit per clock, then saturates and restores the sign.
module fxp_divider #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int QW = WIDTH + FRAC;
    localparam int CW = $clog2(QW);
    localparam logic [CW-1:0]    CNT_INIT = CW'(QW - 1);
    localparam logic [QW-1:0]    LIM_NEG  = QW'(1) << (WIDTH - 1);
    localparam logic [QW-1:0]    LIM_POS  = LIM_NEG - QW'(1);
    localparam logic [WIDTH-1:0] RES_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] RES_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [QW-1:0]    quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             sign_q, sign_d;
    logic             a_neg_q, a_neg_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH+1:0] rem_wide;
    logic             ge;
    logic [WIDTH:0]   rem_step;
    logic [QW-1:0]    quo_step;
    logic [WIDTH-1:0] fin_res;
    logic             fin_sat;

    always_comb begin
        a_mag = data_a[WIDTH-1] ? -data_a : data_a;
        b_mag = data_b[WIDTH-1] ? -data_b : data_b;

        // The dividend sits in the quotient register and is consumed MSB first,
        // while quotient bits are shifted in at the bottom.
        rem_wide = {rem_q, quo_q[QW-1]};
        ge       = rem_wide >= {2'b00, div_q};
        rem_step = ge ? (WIDTH+1)'(rem_wide - {2'b00, div_q}) : rem_wide[WIDTH:0];
        quo_step = {quo_q[QW-2:0], ge};

        fin_sat = quo_step > (sign_q ? LIM_NEG : LIM_POS);
        if (dbz_q) begin
            fin_res = a_neg_q ? RES_MIN : RES_MAX;
        end else if (fin_sat) begin
            fin_res = sign_q ? RES_MIN : RES_MAX;
        end else begin
            fin_res = sign_q ? -quo_step[WIDTH-1:0] : quo_step[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        sign_d   = sign_q;
        a_neg_d  = a_neg_q;
        dbz_d    = dbz_q;
        result_d = result_q;
        flags_d  = flags_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    sign_d  = data_a[WIDTH-1] ^ data_b[WIDTH-1];
                    a_neg_d = data_a[WIDTH-1];
                    div_d   = b_mag;
                    quo_d   = {a_mag, {FRAC{1'b0}}};
                    rem_d   = '0;
                    cnt_d   = CNT_INIT;
                    dbz_d   = (data_b == '0);
                end
            end
            RUN: begin
                rem_d = rem_step;
                quo_d = quo_step;
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    result_d = fin_res;
                    flags_d  = {dbz_q | fin_sat,
                                fin_res[WIDTH-1],
                                fin_res == '0,
                                ~dbz_q & (rem_step != '0)};
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            sign_q   <= 1'b0;
            a_neg_q  <= 1'b0;
            dbz_q    <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            sign_q   <= sign_d;
            a_neg_q  <= a_neg_d;
            dbz_q    <= dbz_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_fxp_divider.sv
// Randomized and directed bench for fxp_divider. Stimulus pushes model results into a
// scoreboard queue, and a monitor pops from it on every done pulse.
module tb_fxp_divider;

    localparam int W   = 16;
    localparam int F   = 8;
    localparam int LAT = W + F;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] data_a = '0;
    logic [W-1:0] data_b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [3:0]   flags;

    fxp_divider #(.WIDTH(W), .FRAC(F)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .data_a (data_a),
        .data_b (data_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flags  (flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   flg;
        int           exp_cyc;
    } exp_t;

    exp_t sb[$];
    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the real-valued quotient.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [3:0] f);
        longint sa, sbv, ma, mb, q, rm, lim;
        bit neg, v, c;
        sa  = $signed(a);
        sbv = $signed(b);
        if (sbv == 0) begin
            r = (sa >= 0) ? 16'h7FFF : 16'h8000;
            v = 1'b1;
            c = 1'b0;
        end else begin
            ma  = (sa < 0) ? -sa : sa;
            mb  = (sbv < 0) ? -sbv : sbv;
            q   = (ma * (64'sd1 << F)) / mb;
            rm  = (ma * (64'sd1 << F)) % mb;
            neg = (sa < 0) != (sbv < 0);
            lim = neg ? 32768 : 32767;
            if (q > lim) begin
                r = neg ? 16'h8000 : 16'h7FFF;
                v = 1'b1;
            end else begin
                r = neg ? 16'(-q) : 16'(q);
                v = 1'b0;
            end
            c = (rm != 0);
        end
        f = {v, r[W-1], (r == '0), c};
    endfunction

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL spurious_done: got done=1, expected no pending transaction (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    chk("result", {16'h0, result}, {16'h0, e.res});
                    chk("flags", {28'h0, flags}, {28'h0, e.flg});
                    chk("latency", cyc, e.exp_cyc);
                    $display("txn a=%h b=%h result=%h flags=%b cycle=%0d", e.a, e.b, result, flags, cyc);
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        logic [W-1:0] r;
        logic [3:0]   f;
        exp_t         e;
        @(negedge clk);
        data_a = a;
        data_b = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            model(a, b, r, f);
            e.a = a; e.b = b; e.res = r; e.flg = f; e.exp_cyc = cyc + LAT;
            sb.push_back(e);
        end
        chk("busy_run", {31'h0, busy}, 32'h1);
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < LAT + 16) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", {31'h0, done}, 32'h1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] va [11] = '{16'h0300, 16'hFD00, 16'h0100, 16'h0100, 16'hFF00,
                              16'h7F00, 16'h8000, 16'h8000, 16'h0000, 16'h0080, 16'h0000};
    logic [W-1:0] vb [11] = '{16'h0200, 16'h0200, 16'h0300, 16'h0000, 16'h0000,
                              16'h0001, 16'h0100, 16'hFFFF, 16'h0100, 16'h8000, 16'h0000};

    initial begin
        exp_t e;
        logic [W-1:0] a, b;
        int k;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_result", {16'h0, result}, 32'h0);
        chk("rst_flags", {28'h0, flags}, 32'h0);
        rst_n = 1'b1;

        // Directed vectors, first one immediately after reset release
        for (int i = 0; i < 11; i++) begin
            issue(va[i], vb[i], 1'b1);
            wait_done();
        end

        // Start pulsed during RUN must be ignored
        issue(16'h0300, 16'h0200, 1'b1);
        repeat (4) @(negedge clk);
        data_a = 16'h0100;
        data_b = 16'h0300;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        repeat (LAT + 6) @(negedge clk);

        // start held high: ignored at DONE->IDLE edge, accepted one edge later
        @(negedge clk);
        data_a = 16'hFD00;
        data_b = 16'h0300;
        start  = 1'b1;
        @(posedge clk);
        #1;
        model(data_a, data_b, e.res, e.flg);
        e.a = data_a; e.b = data_b;
        e.exp_cyc = cyc + LAT;
        sb.push_back(e);
        e.exp_cyc = cyc + 2 * LAT + 2;
        sb.push_back(e);
        wait_done();
        @(negedge clk);
        chk("idle_after_done", {31'h0, busy}, 32'h0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_restart", {31'h0, busy}, 32'h1);
        wait_done();

        // Reset in the middle of RUN aborts with no done pulse
        issue(16'h0300, 16'h0200, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_result", {16'h0, result}, 32'h0);
        chk("abort_flags", {28'h0, flags}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 4) @(negedge clk);
        issue(16'h0100, 16'h0300, 1'b1);
        wait_done();

        // Randomized operands
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 9);
            a = W'($urandom);
            if ($urandom_range(0, 9) == 0) a = 16'h8000;
            if (k == 0)      b = '0;
            else if (k < 4)  b = W'($urandom_range(1, 16'h01FF));
            else             b = W'($urandom);
            if (k < 4 && k > 0 && $urandom_range(0, 1) == 1) b = -b;
            issue(a, b, 1'b1);
            wait_done();
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
